// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One word request at a time; responses return in order.
interface fetch_stage_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, fetches one word at a time from imem
// and fills the IF/ID register, honouring hazard stalls and EX redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pc_en,
  input  logic                 if_id_en,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc_plus4,
  output logic [31:0]          if_id_instr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_pc, req_pc_next;
  logic [31:0] hold_instr, hold_next;
  logic        load;
  logic [31:0] load_instr;
  logic        advance;
  logic        handshake;
  logic [31:0] target;

  assign advance        = pc_en & if_id_en;
  assign target         = {redirect_pc[31:2], 2'b00};
  assign imem.req_valid = (state == REQ);
  assign imem.req_addr  = pc;
  assign handshake      = imem.req_valid & imem.req_ready;
  assign if_id_pc_plus4 = if_id_pc + 32'd4;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    hold_next   = hold_instr;
    load        = 1'b0;
    load_instr  = hold_instr;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (redirect) begin
          pc_next = target;
          if (handshake) state_next = DROP;
        end else if (handshake) begin
          req_pc_next = pc;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (imem.rsp_valid) begin
          if (redirect) begin
            pc_next    = target;
            state_next = REQ;
          end else if (advance) begin
            load       = 1'b1;
            load_instr = imem.rsp_data;
            pc_next    = req_pc + 32'd4;
            state_next = REQ;
          end else begin
            hold_next  = imem.rsp_data;
            state_next = HOLD;
          end
        end else if (redirect) begin
          // The in-flight word is now wrong-path; DROP swallows it when it lands.
          pc_next    = target;
          state_next = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = REQ;
        end else if (advance) begin
          load       = 1'b1;
          pc_next    = req_pc + 32'd4;
          state_next = REQ;
        end
      end
      DROP: begin
        if (redirect) pc_next = target;
        if (imem.rsp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      req_pc     <= req_pc_next;
      hold_instr <= hold_next;
    end
  end

  // A redirect squashes IF/ID even while the hazard unit is holding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (if_id_en) begin
      if (load) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= load_instr;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule
